inta_sequencer: RTL

//   CPU-side interrupt-acknowledge responder for the 8259A-style PIC. It raises INT to the
//   CPU and runs the two-pulse 8086 INTA cycle. It generates the in-service set pulse and
//   the level that the in-service register consumes, and drives the vector byte and the

---
 rtl/inta_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/inta_sequencer.sv
// 8086 two-pulse INTA responder: raises INT, latches the acknowledged level,
// drives the vector and cascade lines, and emits the ISR set / AEOI pulses.
module inta_sequencer #(
  parameter int         SYNC_STAGES    = 2,
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INTA_n,
  input  logic       int_pending,
  input  logic [2:0] highest_priority_int,
  input  logic [4:0] V_A,
  input  logic       AEOI,
  input  logic       SNGL,
  input  logic       S_P,
  input  logic [7:0] IRR_slave,
  input  logic [2:0] slave_id,
  input  logic [2:0] CAS_in,
  output logic       INT,
  output logic       set_isr,
  output logic [2:0] isr_level,
  output logic       aeoi_pulse,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [2:0] CAS_out,
  output logic       cas_oe
);

  typedef enum logic [2:0] {IDLE, REQ, ACK1, GAP, ACK2} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] inta_sync;
  logic                   inta_prev;
  logic                   fall, rise;
  logic                   spurious, cas_match;
  logic                   is_master, casc, owns;

  // Synchroniser and previous-value flop both idle high (INTA_n inactive).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inta_sync <= '1;
      inta_prev <= 1'b1;
    end else begin
      inta_sync <= {inta_sync[SYNC_STAGES-2:0], INTA_n};
      inta_prev <= inta_sync[SYNC_STAGES-1];
    end
  end

  assign fall = inta_prev & ~inta_sync[SYNC_STAGES-1];
  assign rise = ~inta_prev & inta_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (int_pending) state_nxt = REQ;
      REQ:     if (fall)        state_nxt = ACK1;
      ACK1:    if (rise)        state_nxt = GAP;
      GAP:     if (fall)        state_nxt = ACK2;
      ACK2:    if (rise)        state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Level/ownership capture and the two single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isr_level  <= 3'd0;
      spurious   <= 1'b0;
      cas_match  <= 1'b0;
      set_isr    <= 1'b0;
      aeoi_pulse <= 1'b0;
    end else begin
      set_isr    <= 1'b0;
      aeoi_pulse <= 1'b0;
      if (state == REQ && fall) begin
        isr_level <= int_pending ? highest_priority_int : SPURIOUS_LEVEL;
        spurious  <= ~int_pending;
        set_isr   <= int_pending;
      end
      if (state == GAP && fall)
        cas_match <= (CAS_in == slave_id);
      if (state == ACK2 && rise)
        aeoi_pulse <= AEOI & ~spurious;
    end
  end

  assign is_master = ~SNGL & S_P;
  assign casc      = is_master & IRR_slave[isr_level] & ~spurious;
  assign owns      = SNGL | (is_master & ~IRR_slave[isr_level]) | (~SNGL & ~S_P & cas_match);

  always_comb begin
    INT      = 1'b0;
    cas_oe   = 1'b0;
    CAS_out  = 3'd0;
    data_oe  = 1'b0;
    data_out = 8'd0;
    case (state)
      REQ:      INT = 1'b1;
      ACK1,
      GAP:      cas_oe = casc;
      ACK2: begin
        cas_oe  = casc;
        data_oe = owns;
      end
      default: ;
    endcase
    if (cas_oe)  CAS_out  = isr_level;
    if (data_oe) data_out = {V_A, isr_level};
  end

endmodule
